// File: rtl/integer_vector_pkg.sv
// Purpose: shared types and helpers for the integer vector stream source.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package integer_vector_pkg;

    // Sequencer states: wait for start, emit beats, one-cycle completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_t;

    // Number of beats needed to emit a WIDTH-element vector MULTS lanes at a time.
    function automatic int calc_beats(input int width, input int mults);
        return width / mults;
    endfunction

endpackage

// File: rtl/integer_vector_stream_source_vector_bank.sv
// Purpose: WIDTH x BITS element store with one write port and a MULTS-lane read.
// Latency: write lands on the next rising edge; read is combinational from rd_beat.
// Backpressure: none; caller qualifies wr_en.
//
// Ports: clk; wr_en/wr_addr/wr_data write one element; rd_beat selects
// the beat and rd_data[g] returns element rd_beat*MULTS+g.
// Storage is deliberately not reset so contents survive a reset.
module vector_bank
    import integer_vector_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int WIDTH = 30,
    parameter int MULTS = 3,
    parameter int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int BW    = 1
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [BITS-1:0]            wr_data,
    input  logic [BW-1:0]              rd_beat,
    output logic [MULTS-1:0][BITS-1:0] rd_data
);

    logic [BITS-1:0] mem [WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        logic [AW-1:0] idx;
        rd_data = '0;
        idx     = '0;
        for (int g = 0; g < MULTS; g++) begin
            idx        = AW'(int'(rd_beat) * MULTS + g);
            rd_data[g] = mem[idx];
        end
    end

endmodule

// File: rtl/integer_vector_stream_source.sv
// Purpose: holds vectors A and B and streams them MULTS lanes per beat on start.
// Latency: first beat one cycle after start is sampled; done one cycle after last beat.
// Backpressure: none by default; with INTEGER_VECTOR_STREAM_STALL_EN, stall holds the beat.
//
// Ports: clk, rstn (async active-low); wr_en/wr_sel/wr_addr/wr_data load
// bank A (wr_sel=0) or B (wr_sel=1); start launches one stream; busy, out_valid,
// vector_a/vector_b lanes and done describe the stream.
// Optional build macro: INTEGER_VECTOR_STREAM_STALL_EN adds the stall input.
module integer_vector_stream_source
    import integer_vector_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int WIDTH = 30,
    parameter int MULTS = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [$clog2(WIDTH)-1:0]     wr_addr,
    input  logic [BITS-1:0]              wr_data,
    input  logic                         start,
`ifdef INTEGER_VECTOR_STREAM_STALL_EN
    input  logic                         stall,
`endif
    output logic                         busy,
    output logic                         out_valid,
    output logic [MULTS-1:0][BITS-1:0]   vector_a,
    output logic [MULTS-1:0][BITS-1:0]   vector_b,
    output logic                         done
);

    localparam int BEATS = calc_beats(WIDTH, MULTS);
    localparam int AW    = $clog2(WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((WIDTH % MULTS) != 0) begin : g_bad_cfg
        $error("integer_vector_stream_source: WIDTH must be a multiple of MULTS");
    end

    stream_state_t state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          stall_act;
    logic          wr_ok;
    logic [MULTS-1:0][BITS-1:0] rd_a, rd_b;

`ifdef INTEGER_VECTOR_STREAM_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    // Banks are writable whenever no stream is reading them; out-of-range
    // addresses are dropped so a bad index can never alias a real element.
    assign wr_ok = wr_en && (state_q != ST_STREAM) && (32'(wr_addr) < WIDTH);

    vector_bank #(.BITS(BITS), .WIDTH(WIDTH), .MULTS(MULTS), .AW(AW), .BW(BW)) u_bank_a (
        .clk     (clk),
        .wr_en   (wr_ok && !wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_beat (beat_q),
        .rd_data (rd_a)
    );

    vector_bank #(.BITS(BITS), .WIDTH(WIDTH), .MULTS(MULTS), .AW(AW), .BW(BW)) u_bank_b (
        .clk     (clk),
        .wr_en   (wr_ok && wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_beat (beat_q),
        .rd_data (rd_b)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    beat_d  = '0;
                end
            end
            ST_STREAM: begin
                if (!stall_act) begin
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_d = ST_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start here is intentionally not queued.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign busy      = (state_q == ST_STREAM);
    assign out_valid = busy && !stall_act;
    assign done      = (state_q == ST_DONE);
    assign vector_a  = out_valid ? rd_a : '0;
    assign vector_b  = out_valid ? rd_b : '0;

endmodule

// File: doc/integer_vector_stream_source.md
INTEGER_VECTOR_STREAM_SOURCE -- requirements
Module: integer_vector_stream_source

Interface
REQ-001 Parameter BITS, default 16, element width in bits.
REQ-002 Parameter WIDTH, default 30, elements per vector; WIDTH SHALL be a multiple of MULTS (elaboration error otherwise).
REQ-003 Parameter MULTS, default 3, lanes emitted per beat; BEATS = WIDTH/MULTS.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  element write strobe.
REQ-007 wr_sel  input  1  write target: 0 = vector A bank, 1 = vector B bank.
REQ-008 wr_addr  input  $clog2(WIDTH)  element index 0..WIDTH-1.
REQ-009 wr_data  input  BITS  element value.
REQ-010 start  input  1  single-cycle pulse requesting one stream of both vectors.
REQ-011 busy  output  1  high in STREAM state.
REQ-012 out_valid  output  1  beat valid, drives downstream in_valid.
REQ-013 vector_a  output  BITS x [MULTS]  lane g = A[beat*MULTS+g].
REQ-014 vector_b  output  BITS x [MULTS]  lane g = B[beat*MULTS+g].
REQ-015 done  output  1  one-cycle pulse the cycle after the last beat.

Function
REQ-016 FSM states SHALL be IDLE, STREAM, DONE; reset state IDLE.
REQ-017 IDLE: start=1 SHALL transition to STREAM with beat counter = 0; otherwise stay.
REQ-018 First beat SHALL appear (out_valid=1) the cycle after start is sampled; latency 1.
REQ-019 STREAM: one beat per cycle, beat counter increments 0..BEATS-1, out_valid=1 exactly BEATS consecutive cycles (default build).
REQ-020 After beat BEATS-1, SHALL go to DONE for exactly one cycle (done=1), then IDLE.
REQ-021 start in STREAM or DONE SHALL be ignored (not queued).
REQ-022 When out_valid=0, vector_a and vector_b SHALL drive all-zero.
REQ-023 Writes SHALL be accepted only in IDLE and DONE; wr_en in STREAM SHALL be dropped.
REQ-024 wr_en with wr_addr >= WIDTH SHALL be ignored with no bank change.
REQ-025 Write and start in same IDLE cycle: write SHALL take effect before the stream reads that element (write-first).
REQ-026 Elements SHALL be passed unmodified; no arithmetic, no sign interpretation.

Reset
REQ-027 rstn low SHALL immediately force IDLE, beat counter 0, busy=0, out_valid=0, done=0, vector_a/vector_b=0.
REQ-028 Reset mid-stream SHALL abort the stream with no done pulse.
REQ-029 Bank storage SHALL NOT be reset; contents retained across reset, undefined after power-up.

Configuration
REQ-030 Macro INTEGER_VECTOR_STREAM_STALL_EN, when defined, SHALL add input stall (1 bit, after start in port list).
REQ-031 With macro: stall=1 in STREAM SHALL hold the beat counter, force out_valid=0 and lanes zero; stream resumes at same beat when stall=0; stall ignored outside STREAM.
REQ-032 Without macro: no stall port, behaviour per REQ-019.

Structure
REQ-033 Package integer_vector_pkg SHALL hold the FSM state enum and a function returning BEATS from WIDTH and MULTS.
REQ-034 One sub-module vector_bank (WIDTH x BITS storage, one write port, MULTS-lane combinational read at beat index) SHALL be instantiated twice (A, B).

Verification
REQ-035 Write A[i]=i+1, B[i]=2 for i=0..29, start -> 10 beats; beat 0 vector_a={1,2,3}, vector_b={2,2,2}; beat 9 vector_a={28,29,30}; done 1 cycle after beat 9.
REQ-036 Feed outputs to dot-product block with data of REQ-035 -> dot product result 930 (mod 2^16).
REQ-037 start during beat 4 and wr_en to A[0]=0xFFFF during STREAM -> no second stream, A[0] still 1 on next stream.
REQ-038 rstn low during beat 5 -> out_valid, busy, lanes 0 same cycle, no done; next start streams from beat 0 with original data.
REQ-039 wr_addr=30 with wr_data=0xABCD -> no element changes; full stream matches REQ-035.
REQ-040 STALL_EN build: stall=1 for 3 cycles at beat 2 -> out_valid low 3 cycles, then beat 2 vector_a={7,8,9}; total 13 cycles start to done.
